alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared `alu_8bit` datapath. It accepts operand/opcode transactions from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU from registered operands and returns the registered result, tagged with the requester ID, on a single response channel with backpressure. It sits between the `tt_um_*` top-level glue and the one `alu_8bit` instance, which it treats as an external combinational unit.

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for the
// shared alu_8bit datapath.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/a/b/sel           requester N transaction (N = 0, 1)
//   reqN_ready                   requester N accepted this cycle (combinational)
//   alu_a, alu_b, alu_sel        registered operands/opcode to alu_8bit
//   alu_y                        combinational result from alu_8bit
//   rsp_valid/id/y, rsp_ready    tagged response channel with backpressure
//   busy                         high while in EXEC or RESP
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       req1_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_y,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_id;
  logic   gnt_any;
  logic   gnt_id;

  // Arbitration: a lone requester wins; under contention the one not granted last wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? ~last_id : req1_valid;
  end

  // Ready only to the winner, only in IDLE, never during reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == ST_IDLE && gnt_any) begin
      req0_ready = ~gnt_id;
      req1_ready = gnt_id;
    end
  end

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= 8'h00;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_sel   <= 3'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            alu_a   <= gnt_id ? req1_a   : req0_a;
            alu_b   <= gnt_id ? req1_b   : req0_b;
            alu_sel <= gnt_id ? req1_sel : req0_sel;
            rsp_id  <= gnt_id;
            last_id <= gnt_id;
            busy    <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU has had a full cycle on the registered operands.
          rsp_y     <= alu_y;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed testbench for alu_arbiter with an adder ALU model.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       req0_ready, req1_ready;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_y;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  // ALU stand-in: plain 8-bit add.
  assign alu_y = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nresp;
    int last_cyc;
    logic exp_id;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_sel = 3'd0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_sel = 3'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_y",     32'(rsp_y),     32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    // Single request; ready must be masked while rst is high
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_sel = 3'd0;
    #1 check("rst_ready0_masked", 32'(req0_ready), 32'd0);
    rst = 1'b0;
    #1 check("single_ready0", 32'(req0_ready), 32'd1);
    check("single_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("single_alu_a",   32'(alu_a),   32'h05);
    check("single_alu_b",   32'(alu_b),   32'h03);
    check("single_alu_sel", 32'(alu_sel), 32'd0);
    check("single_busy",    32'(busy),    32'd1);
    check("single_exec_ready0", 32'(req0_ready), 32'd0);
    check("single_exec_rspv",   32'(rsp_valid),  32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id",    32'(rsp_id),    32'd0);
    check("single_rsp_y",     32'(rsp_y),     32'h08);
    @(negedge clk);
    check("single_rsp_clear", 32'(rsp_valid), 32'd0);
    check("single_idle_busy", 32'(busy),      32'd0);

    // Contention from a fresh reset: 0,1,0,1 every 3 cycles
    do_reset();
    req0_a = 8'h01; req0_b = 8'h01; req0_sel = 3'd0;
    req1_a = 8'hF0; req1_b = 8'h20; req1_sel = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("cont_one_ready", 32'({req1_ready, req0_ready}), 32'b01);
    nresp = 0; last_cyc = 0; exp_id = 1'b0;
    for (int cyc = 1; cyc <= 20 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("cont_rsp_id", 32'(rsp_id), 32'(exp_id));
        check("cont_rsp_y",  32'(rsp_y),  exp_id ? 32'h10 : 32'h02);
        if (nresp > 0) check("cont_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        exp_id   = ~exp_id;
        nresp++;
      end
    end
    check("cont_count", 32'(nresp), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure: 5 stalled cycles in RESP with req1 waiting
    req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h09; req0_sel = 3'd3;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_alu_a", 32'(alu_a), 32'h07);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_sel = 3'd2;
    @(negedge clk);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid",  32'(rsp_valid),  32'd1);
      check("bp_hold_y",      32'(rsp_y),      32'h10);
      check("bp_hold_id",     32'(rsp_id),     32'd0);
      check("bp_hold_ready1", 32'(req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 32'(rsp_valid),  32'd0);
    check("bp_ready1",   32'(req1_ready), 32'd1);
    @(negedge clk);
    check("bp_req1_alu_a",   32'(alu_a),   32'h11);
    check("bp_req1_alu_b",   32'(alu_b),   32'h22);
    check("bp_req1_alu_sel", 32'(alu_sel), 32'd2);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_req1_rsp_id", 32'(rsp_id), 32'd1);
    check("bp_req1_rsp_y",  32'(rsp_y),  32'h33);
    @(negedge clk);

    // Withdrawn request: req1 valid for one EXEC cycle only
    req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03; req0_sel = 3'd4;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h01;
    #1 check("wd_exec_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    check("wd_rsp_id", 32'(rsp_id), 32'd0);
    check("wd_rsp_y",  32'(rsp_y),  32'h05);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wd_no_rsp",  32'(rsp_valid), 32'd0);
      check("wd_no_busy", 32'(busy),      32'd0);
    end

    // Reset in RESP discards the response and restores arbitration priority
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_sel = 3'd5;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("mr_rsp_valid_pre", 32'(rsp_valid), 32'd1);
    rst = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_busy",      32'(busy),      32'd0);
    check("mr_alu_a",     32'(alu_a),     32'd0);
    check("mr_alu_b",     32'(alu_b),     32'd0);
    check("mr_alu_sel",   32'(alu_sel),   32'd0);
    check("mr_rsp_y",     32'(rsp_y),     32'd0);
    rst = 1'b0; rsp_ready = 1'b1;
    req0_a = 8'h01; req0_b = 8'h01; req1_a = 8'hF0; req1_b = 8'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("mr_grant0_ready0", 32'(req0_ready), 32'd1);
    check("mr_grant0_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("mr_grant0_alu_a", 32'(alu_a), 32'h01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("mr_grant0_rsp_id", 32'(rsp_id), 32'd0);
    check("mr_grant0_rsp_y",  32'(rsp_y),  32'h02);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
